// File: rtl/cdc_strobe_arbiter_if.sv
// Bundle of requester-side and channel-side signals around cdc_strobe_arbiter.
// The master modport is the arbiter's view; slave is the view of whatever drives and observes it.
interface cdc_strobe_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req_strobe;
    logic [N_REQ-1:0] req_overflow;
    logic             source_strobe;
    logic             source_stall;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             timeout_err;

    modport master (
        input  req_strobe,
        input  source_stall,
        output req_overflow,
        output source_strobe,
        output grant_id,
        output busy,
        output timeout_err
    );

    modport slave (
        output req_strobe,
        output source_stall,
        input  req_overflow,
        input  source_strobe,
        input  grant_id,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/cdc_strobe_arbiter.sv
// Round-robin sharing of one single-strobe CDC handshake channel between N_REQ requesters.
// Defining ARB_TIMEOUT_EN adds a stall watchdog that sets timeout_err and frees the channel.
module cdc_strobe_arbiter #(
    parameter int N_REQ         = 4,
    parameter int CNT_W         = 3,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                 source_clk,
    input  logic                 source_reset_n,
    cdc_strobe_arbiter_if.master bus
);
    localparam int              ID_W    = $clog2(N_REQ);
    localparam logic [ID_W:0]   NREQ_V  = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [N_REQ-1:0] w_nonzero;
    logic [N_REQ-1:0] w_dec;
    logic [N_REQ-1:0] w_ovf;
    logic [ID_W:0]    w_sum;
    logic             w_sel_valid;
    logic [ID_W-1:0]  w_sel_idx;
    logic             w_grant;
    logic             w_to_hit;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_grant_id;
    logic             r_source_strobe;

    // Scan offsets from the highest down so the smallest offset from the pointer wins.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_sum       = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            w_sum = {1'b0, r_ptr} + (ID_W + 1)'(j);
            if (w_sum >= NREQ_V) begin
                w_sum = w_sum - NREQ_V;
            end
            if (w_nonzero[w_sum[ID_W-1:0]]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_grant = (r_state == IDLE) && w_sel_valid && !bus.source_stall;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        logic [CNT_W-1:0] r_cnt;
        logic             r_ovf;

        assign w_dec[gi]     = w_grant && (w_sel_idx == ID_W'(gi));
        assign w_nonzero[gi] = (r_cnt != '0);
        assign w_ovf[gi]     = r_ovf;

        // A strobe arriving together with this requester's grant leaves the count unchanged.
        always_ff @(posedge source_clk or negedge source_reset_n) begin
            if (!source_reset_n) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (bus.req_strobe[gi] && !w_dec[gi]) begin
                if (r_cnt == CNT_MAX) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (!bus.req_strobe[gi] && w_dec[gi]) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            r_ptr           <= '0;
            r_grant_id      <= '0;
            r_source_strobe <= 1'b0;
        end else begin
            r_source_strobe <= (r_state == ISSUE);
            if (w_grant) begin
                r_grant_id <= w_sel_idx;
                r_ptr      <= (w_sel_idx == LAST_ID) ? '0 : w_sel_idx + 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(STALL_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(STALL_TIMEOUT - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    // Fires only on the last allowed wait cycle when the channel has made no progress.
    assign w_to_hit = (r_to_cnt == TO_LAST) &&
                      (((r_state == WAIT_BUSY) && !bus.source_stall) ||
                       ((r_state == WAIT_DONE) &&  bus.source_stall));

    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_to_cnt <= '0;
            end else if ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign w_to_hit        = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.source_stall) begin
                    w_next_state = WAIT_DONE;
                end else if (w_to_hit) begin
                    w_next_state = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.source_stall || w_to_hit) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign bus.req_overflow  = w_ovf;
    assign bus.source_strobe = r_source_strobe;
    assign bus.grant_id      = r_grant_id;
    assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_cdc_strobe_arbiter.sv
// Directed bench for cdc_strobe_arbiter: a cycle table for the single-transfer timing plus
// hand sequences for round-robin order, saturation, same-cycle inc/dec, watchdog and reset abort.
module tb_cdc_strobe_arbiter;
    localparam int N_REQ = 4;

    logic source_clk     = 1'b0;
    logic source_reset_n = 1'b1;

    always #5 source_clk = ~source_clk;

    cdc_strobe_arbiter_if #(.N_REQ(N_REQ)) arbBus ();

    cdc_strobe_arbiter #(
        .N_REQ        (N_REQ),
        .CNT_W        (3),
        .STALL_TIMEOUT(64)
    ) dut (
        .source_clk    (source_clk),
        .source_reset_n(source_reset_n),
        .bus           (arbBus)
    );

    typedef struct {
        logic [3:0] req;
        logic       stall;
        logic       expStrobe;
        logic       expBusy;
        logic [1:0] expGid;
    } vec_t;

    vec_t vecs [7];
    int   numChecks   = 0;
    int   numErrors   = 0;
    int   strobeCount = 0;
    int   base;

    always @(negedge source_clk) begin
        if (arbBus.source_strobe === 1'b1) begin
            strobeCount <= strobeCount + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic stall);
        arbBus.req_strobe   = req;
        arbBus.source_stall = stall;
    endtask

    task automatic stepCycle();
        @(posedge source_clk);
        @(negedge source_clk);
    endtask

    task automatic doReset();
        applyStimulus(4'b0000, 1'b0);
        source_reset_n = 1'b0;
        @(negedge source_clk);
        @(negedge source_clk);
        source_reset_n = 1'b1;
        @(negedge source_clk);
    endtask

    // Waits for the next strobe, answers with a two-cycle stall, then expects the arbiter idle.
    task automatic serveOne(input logic [1:0] expId, input string name);
        int waited = 0;
        while (arbBus.source_strobe !== 1'b1 && waited < 40) begin
            @(negedge source_clk);
            waited++;
        end
        if (arbBus.source_strobe !== 1'b1) begin
            checkOutput({name, " strobe wait"}, 32'(arbBus.source_strobe), 32'd1);
        end else begin
            checkOutput({name, " grant_id"}, 32'(arbBus.grant_id), 32'(expId));
            arbBus.source_stall = 1'b1;
            @(negedge source_clk);
            @(negedge source_clk);
            arbBus.source_stall = 1'b0;
            @(negedge source_clk);
            checkOutput({name, " busy after stall"}, 32'(arbBus.busy), 32'd0);
        end
    endtask

    task automatic expectQuiet(input int cycles, input int expTotal, input string name);
        repeat (cycles) @(negedge source_clk);
        #1;
        checkOutput(name, 32'(strobeCount - base), 32'(expTotal));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{4'b0100, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[2] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd2};
        vecs[3] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2};
        vecs[4] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2};
        vecs[5] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[6] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd2};

        applyStimulus(4'b0000, 1'b0);
        #2 source_reset_n = 1'b0;
        @(negedge source_clk);
        checkOutput("reset source_strobe", 32'(arbBus.source_strobe), 32'd0);
        checkOutput("reset busy", 32'(arbBus.busy), 32'd0);
        checkOutput("reset grant_id", 32'(arbBus.grant_id), 32'd0);
        checkOutput("reset req_overflow", 32'(arbBus.req_overflow), 32'd0);
        checkOutput("reset timeout_err", 32'(arbBus.timeout_err), 32'd0);
        @(negedge source_clk);
        source_reset_n = 1'b1;
        @(negedge source_clk);

        // single strobe on requester 2, cycle by cycle
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].req, vecs[i].stall);
            stepCycle();
            checkOutput($sformatf("t1 row%0d source_strobe", i), 32'(arbBus.source_strobe), 32'(vecs[i].expStrobe));
            checkOutput($sformatf("t1 row%0d busy", i), 32'(arbBus.busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("t1 row%0d grant_id", i), 32'(arbBus.grant_id), 32'(vecs[i].expGid));
        end

        // all four together from pointer 0
        doReset();
        #1 base = strobeCount;
        applyStimulus(4'b1111, 1'b0);
        stepCycle();
        applyStimulus(4'b0000, 1'b0);
        serveOne(2'd0, "t2 first");
        serveOne(2'd1, "t2 second");
        serveOne(2'd2, "t2 third");
        serveOne(2'd3, "t2 fourth");
        expectQuiet(20, 4, "t2 strobe total");

        // saturation of requester 1 while the channel is stalled
        for (int p = 1; p <= 9; p++) begin
            applyStimulus(4'b0010, 1'b1);
            stepCycle();
            if (p == 7) checkOutput("t3 overflow at 7", 32'(arbBus.req_overflow), 32'd0);
            if (p == 8) checkOutput("t3 overflow at 8", 32'(arbBus.req_overflow), 32'b0010);
        end
        checkOutput("t3 busy while stalled", 32'(arbBus.busy), 32'd0);
        applyStimulus(4'b0000, 1'b0);
        #1 base = strobeCount;
        for (int k = 0; k < 7; k++) begin
            serveOne(2'd1, $sformatf("t3 serve%0d", k));
        end
        expectQuiet(20, 7, "t3 strobe total");
        checkOutput("t3 overflow sticky", 32'(arbBus.req_overflow), 32'b0010);

        // strobe on requester 0 in the same cycle as its grant
        #1 base = strobeCount;
        applyStimulus(4'b0001, 1'b0);
        stepCycle();
        applyStimulus(4'b0001, 1'b0);
        stepCycle();
        checkOutput("t4 busy at grant", 32'(arbBus.busy), 32'd1);
        checkOutput("t4 grant_id at grant", 32'(arbBus.grant_id), 32'd0);
        applyStimulus(4'b0000, 1'b0);
        serveOne(2'd0, "t4 first");
        serveOne(2'd0, "t4 second");
        expectQuiet(20, 2, "t4 strobe total");

        // channel stall held for 100 cycles
        #1 base = strobeCount;
        applyStimulus(4'b1000, 1'b0);
        stepCycle();
        applyStimulus(4'b0000, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("t5 strobe", 32'(arbBus.source_strobe), 32'd1);
        checkOutput("t5 grant_id", 32'(arbBus.grant_id), 32'd3);
        applyStimulus(4'b0000, 1'b1);
        repeat (63) stepCycle();
        checkOutput("t5 busy before limit", 32'(arbBus.busy), 32'd1);
        checkOutput("t5 timeout_err before limit", 32'(arbBus.timeout_err), 32'd0);
        stepCycle();
`ifdef ARB_TIMEOUT_EN
        checkOutput("t5 busy at limit", 32'(arbBus.busy), 32'd0);
        checkOutput("t5 timeout_err at limit", 32'(arbBus.timeout_err), 32'd1);
`else
        checkOutput("t5 busy at limit", 32'(arbBus.busy), 32'd1);
        checkOutput("t5 timeout_err at limit", 32'(arbBus.timeout_err), 32'd0);
`endif
        repeat (36) stepCycle();
`ifdef ARB_TIMEOUT_EN
        checkOutput("t5 busy late", 32'(arbBus.busy), 32'd0);
        checkOutput("t5 timeout_err late", 32'(arbBus.timeout_err), 32'd1);
`else
        checkOutput("t5 busy late", 32'(arbBus.busy), 32'd1);
        checkOutput("t5 timeout_err late", 32'(arbBus.timeout_err), 32'd0);
`endif
        applyStimulus(4'b0000, 1'b0);
        repeat (3) stepCycle();
        checkOutput("t5 busy after release", 32'(arbBus.busy), 32'd0);
        expectQuiet(10, 1, "t5 strobe total");

        // reset in WAIT_DONE with requester 2 still pending
        applyStimulus(4'b0101, 1'b0);
        stepCycle();
        applyStimulus(4'b0000, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("t6 strobe", 32'(arbBus.source_strobe), 32'd1);
        checkOutput("t6 grant_id", 32'(arbBus.grant_id), 32'd0);
        applyStimulus(4'b0000, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("t6 busy in wait", 32'(arbBus.busy), 32'd1);
        source_reset_n = 1'b0;
        #1;
        checkOutput("t6 reset source_strobe", 32'(arbBus.source_strobe), 32'd0);
        checkOutput("t6 reset busy", 32'(arbBus.busy), 32'd0);
        checkOutput("t6 reset grant_id", 32'(arbBus.grant_id), 32'd0);
        checkOutput("t6 reset req_overflow", 32'(arbBus.req_overflow), 32'd0);
        checkOutput("t6 reset timeout_err", 32'(arbBus.timeout_err), 32'd0);
        @(negedge source_clk);
        source_reset_n = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        #1 base = strobeCount;
        expectQuiet(20, 0, "t6 no strobe after reset");
        checkOutput("t6 busy after reset", 32'(arbBus.busy), 32'd0);
        @(negedge source_clk);
        applyStimulus(4'b0010, 1'b0);
        stepCycle();
        applyStimulus(4'b0000, 1'b0);
        serveOne(2'd1, "t6 new request");
        expectQuiet(10, 1, "t6 strobe total");

        $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
        $finish;
    end
endmodule

// File: doc/cdc_strobe_arbiter.md
Name: cdc_strobe_arbiter

Overview:
Source-domain controller that shares one single-strobe CDC handshake channel between N_REQ requesters. It counts pending strobes per requester and grants the channel round-robin. Each grant issues a one-cycle source_strobe and waits for the channel's stall to rise and then fall. It sits wholly in the source clock domain, directly in front of the strobe-crossing handshake.

Parameters:
N_REQ, 4, number of requesters (2..16)
CNT_W, 3, width of each per-requester pending-strobe counter (saturates at 2^CNT_W-1)
STALL_TIMEOUT, 64, cycles in WAIT_BUSY+WAIT_DONE before timeout (used only with ARB_TIMEOUT_EN)

Ports:
source_clk  in  1  single clock; all logic on its rising edge
source_reset_n  in  1  asynchronous, active-low reset
req_strobe  in  N_REQ  one-cycle strobe per requester; any number may be high together
req_overflow  out  N_REQ  sticky; a strobe was dropped because that requester's counter was saturated
source_strobe  out  1  one-cycle strobe to the handshake channel
source_stall  in  1  channel busy indication from the handshake
grant_id  out  $clog2(N_REQ)  requester served by the current/last transfer
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async assert, sync release):
  - pending counters = 0, req_overflow = 0, source_strobe = 0, grant_id = 0, busy = 0, timeout_err = 0.
  - state = IDLE; round-robin pointer = 0.
- Counters, per requester, every cycle:
  - inc = req_strobe[i]; dec = (grant to i issued this cycle).
  - inc & dec -> unchanged. inc only -> +1. dec only -> -1.
  - inc at max with no dec -> unchanged and req_overflow[i] set (stays set until reset).
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Condition to grant: any counter nonzero AND source_stall == 0.
  - Selection: first nonzero index starting at the pointer, wrapping modulo N_REQ.
  - On grant, next cycle: grant_id = selected index; that counter decrements; pointer = index+1 (wraps); go to ISSUE.
  - If source_stall is high, remain in IDLE.
- ISSUE: source_strobe = 1 for exactly this one cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for source_stall == 1, then go to WAIT_DONE.
- WAIT_DONE: wait for source_stall == 0, then go to IDLE. The next grant can issue from IDLE in the following cycle.
- Latency:
  - req_strobe high at edge E0 (idle, all counters zero) -> counter = 1 after E0.
  - Grant registered at E1; source_strobe high for the cycle after E2.
  - Minimum strobe spacing is 4 cycles plus channel stall time.
- busy = (state != IDLE). grant_id holds its value between grants.
- No strobe is lost unless its counter saturates. Total source_strobes issued = total accepted req_strobes.
- A reset asserted mid-transfer aborts immediately: all counts are discarded and no further strobe is issued.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BUSY and WAIT_DONE and clears on entering ISSUE.
  - When it reaches STALL_TIMEOUT, timeout_err is set (sticky until reset) and the FSM returns to IDLE.
  - The granted strobe is not re-queued.
- Undefined: no counter is built, timeout_err is tied to 0, and the FSM waits indefinitely.

Test Plan:
1. Single strobe on req_strobe[2] with the channel idle -> source_strobe 2 cycles later, grant_id=2, busy high until the stall falls.
2. All 4 requesters strobe in the same cycle, pointer=0 -> grants in order 0,1,2,3; exactly 4 source_strobes.
3. req_strobe[1] pulses 9 times during a long stall with CNT_W=3 -> 7 strobes issued for requester 1 and req_overflow[1]=1.
4. req_strobe[0] arrives in the same cycle as the grant of requester 0 with count 1 -> count stays 1 and one further strobe follows.
5. source_stall held high 100 cycles with ARB_TIMEOUT_EN, STALL_TIMEOUT=64 -> timeout_err=1 after 64 cycles, FSM back in IDLE. Without the macro -> timeout_err stays 0 and the FSM remains in WAIT_DONE.
6. source_reset_n asserted in WAIT_DONE with counts pending -> all outputs 0 immediately; after release, no source_strobe until a new req_strobe.
